bcd_scan_ctrl: RTL

BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

---
 rtl/bcd_scan_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bcd_scan_ctrl.sv
// 9-bit binary to 3-digit BCD converter (shift-and-add-3) driving a multiplexed 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module bcd_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [8:0]  bin,
   output logic [11:0] bcd,
   output logic        done,
   output logic [2:0]  an,
   output logic [6:0]  seg
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

   state_e         state_q, state_d;
   logic [8:0]     sreg_q, sreg_d;
   logic [11:0]    acc_q, acc_d;
   logic [11:0]    adj;
   logic [3:0]     cnt_q, cnt_d;
   logic [11:0]    bcd_q, bcd_d;
   logic           done_q, done_d;

   logic [CW-1:0]  scan_q, scan_d;
   logic           wrap;
   logic [1:0]     sel_q, sel_d;
   logic [2:0]     an_q, an_d;
   logic [6:0]     seg_q, seg_d;
   logic [3:0]     nib;
   logic           blank;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // in_ready also waits out the done cycle, so a new capture never overlaps the result strobe.
   assign in_ready = (state_q == IDLE) && !done_q;

   // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;
      adj     = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               sreg_d  = bin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {acc_d, sreg_d} = {adj[10:0], sreg_q, 1'b0};
            cnt_d           = cnt_q + 4'd1;
            if (cnt_q == 4'd8) state_d = LATCH;
         end
         LATCH: begin
            bcd_d   = acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = done_q;

   assign wrap = (scan_q == CW'(REFRESH_DIV - 1));

   always_comb begin
      scan_d = wrap ? '0 : scan_q + CW'(1);
      sel_d  = sel_q;
      if (wrap) begin
         case (sel_q)
            2'd0:    sel_d = 2'd1;
            2'd1:    sel_d = 2'd2;
            default: sel_d = 2'd0;
         endcase
      end else if (sel_q == 2'd3) begin
         sel_d = 2'd0;
      end
   end

   // The display reads only the registered result, never the in-flight accumulator.
   always_comb begin
      nib   = bcd_q[3:0];
      blank = 1'b0;
      an_d  = 3'b110;
      case (sel_q)
         2'd1: begin
            nib  = bcd_q[7:4];
            an_d = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (bcd_q[11:4] == 8'd0);
`endif
         end
         2'd2: begin
            nib  = bcd_q[11:8];
            an_d = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (bcd_q[11:8] == 4'd0);
`endif
         end
         default: begin
            nib  = bcd_q[3:0];
            an_d = 3'b110;
         end
      endcase
      seg_d = blank ? 7'b1111111 : seg7(nib);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q <= '0;
         sel_q  <= 2'd0;
         an_q   <= 3'b110;
         seg_q  <= 7'b1000000;
      end else begin
         scan_q <= scan_d;
         sel_q  <= sel_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule
